// File: rtl/stream_pkg.sv
// Shared stream-datapath definitions: default data width, arbiter state
// encoding and a constant-foldable clog2 helper.
package stream_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Ceiling log2 usable in parameter expressions; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after i_last_grant,
// scanning upward modulo N_SRC.
module rr_pick #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_SRC-1:0] i_req,
  input  logic [ID_W-1:0]  i_last_grant,
  output logic             o_found,
  output logic [ID_W-1:0]  o_grant_id
);

  logic [ID_W-1:0] w_idx;

  // Scan from the farthest candidate back to the nearest so the nearest
  // requester is the last write and therefore wins.
  always_comb begin
    o_found    = 1'b0;
    o_grant_id = '0;
    w_idx      = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      w_idx = ID_W'((int'(i_last_grant) + k) % N_SRC);
      if (i_req[w_idx]) begin
        o_found    = 1'b1;
        o_grant_id = w_idx;
      end
    end
  end

endmodule

// File: rtl/vr_rr_arbiter.sv
// Round-robin valid/ready arbiter with bounded bursts feeding one registered
// full-throughput output stage.
module vr_rr_arbiter #(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = stream_pkg::DATA_W,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        s_valid,
  input  logic [N_SRC*DATA_W-1:0] s_data,
  output logic [N_SRC-1:0]        s_ready,
  output logic                    m_valid,
  output logic [DATA_W-1:0]       m_data,
  output logic [ID_W-1:0]         m_src_id,
  input  logic                    m_ready,
  output logic                    busy
);

  import stream_pkg::*;

  localparam int CNT_W = clog2(MAX_BURST + 1);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [ID_W-1:0]   r_grant_id;
  logic [ID_W-1:0]   w_grant_id_nxt;
  logic [ID_W-1:0]   r_last_grant;
  logic [ID_W-1:0]   w_last_grant_nxt;
  logic [ID_W-1:0]   w_pick_id;
  logic              w_pick_found;
  logic [CNT_W-1:0]  r_burst_cnt;
  logic [CNT_W-1:0]  w_burst_cnt_nxt;
  logic [CNT_W-1:0]  w_burst_cnt_inc;
  logic              w_load_en;
  logic              w_beat;
  logic [N_SRC-1:0]  w_s_ready;
  logic [DATA_W-1:0] w_src_data [N_SRC];

  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic [ID_W-1:0]   r_m_src_id;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      w_src_data[i] = s_data[i*DATA_W +: DATA_W];
    end
  end

  rr_pick #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_pick (
    .i_req        (s_valid),
    .i_last_grant (r_last_grant),
    .o_found      (w_pick_found),
    .o_grant_id   (w_pick_id)
  );

  // Handshake: a beat moves on a rising edge where valid and ready are both
  // high. s_ready depends only on registered state and m_ready, never on
  // s_valid, so sources may wait for ready before raising valid.
  assign w_load_en = !r_m_valid || m_ready;

  always_comb begin
    w_s_ready = '0;
    if (r_state == ST_GRANT && w_load_en) w_s_ready[r_grant_id] = 1'b1;
  end

  assign w_beat          = |(w_s_ready & s_valid);
  assign w_burst_cnt_inc = r_burst_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_id_nxt   = r_grant_id;
    w_last_grant_nxt = r_last_grant;
    w_burst_cnt_nxt  = r_burst_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt     = ST_GRANT;
          w_grant_id_nxt  = w_pick_id;
          w_burst_cnt_nxt = '0;
        end
      end
      ST_GRANT: begin
        // A dropped valid ends the grant even when the output is stalled.
        if (!s_valid[r_grant_id]) begin
          w_state_nxt      = ST_IDLE;
          w_last_grant_nxt = r_grant_id;
        end else if (w_beat) begin
          w_burst_cnt_nxt = w_burst_cnt_inc;
          if (w_burst_cnt_inc == CNT_W'(MAX_BURST)) begin
            w_state_nxt      = ST_IDLE;
            w_last_grant_nxt = r_grant_id;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= ID_W'(N_SRC - 1);
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_burst_cnt  <= w_burst_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_src_id <= '0;
    end else if (w_beat) begin
      r_m_valid  <= 1'b1;
      r_m_data   <= w_src_data[r_grant_id];
      r_m_src_id <= r_grant_id;
    end else if (m_ready) begin
      r_m_valid  <= 1'b0;
    end
  end

  assign s_ready  = w_s_ready;
  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign m_src_id = r_m_src_id;
  assign busy     = (r_state == ST_GRANT);

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Directed bench for vr_rr_arbiter: a MAX_BURST=4 and a MAX_BURST=1 instance,
// each checked every cycle against a spec-level model plus literal sequences.
module tb_vr_rr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int IDW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    vld  [2];
  logic [N*DW-1:0] dat  [2];
  logic            mrdy [2];
  logic [N-1:0]    sr   [2];
  logic            mvo  [2];
  logic [DW-1:0]   mdo  [2];
  logic [IDW-1:0]  mido [2];
  logic            busyo[2];

  vr_rr_arbiter #(.N_SRC(N), .DATA_W(DW), .MAX_BURST(4), .ID_W(IDW)) u_dut4 (
    .clk(clk), .rst(rst), .s_valid(vld[0]), .s_data(dat[0]), .s_ready(sr[0]),
    .m_valid(mvo[0]), .m_data(mdo[0]), .m_src_id(mido[0]), .m_ready(mrdy[0]),
    .busy(busyo[0])
  );

  vr_rr_arbiter #(.N_SRC(N), .DATA_W(DW), .MAX_BURST(1), .ID_W(IDW)) u_dut1 (
    .clk(clk), .rst(rst), .s_valid(vld[1]), .s_data(dat[1]), .s_ready(sr[1]),
    .m_valid(mvo[1]), .m_data(mdo[1]), .m_src_id(mido[1]), .m_ready(mrdy[1]),
    .busy(busyo[1])
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input int src, input int n);
    return (DW'(src) << 24) | (32'h0000_00A0 + DW'(n));
  endfunction

  function automatic logic [IDW+DW-1:0] ent(input int src, input int n);
    return {IDW'(src), data_of(src, n)};
  endfunction

  function automatic int mb(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  // ---------------- source data driver ----------------
  // Each source presents base + number of beats already accepted, so data is
  // stable while waiting and advances only after a handshake.
  int seq [2][N];
  logic [N-1:0] take [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) take[d] = vld[d] & sr[d];
  end

  always @(posedge clk) begin
    logic rs;
    rs = rst;
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        if (rs) seq[d][i] = 0;
        else if (take[d][i] === 1'b1) seq[d][i]++;
        dat[d][i*DW +: DW] = data_of(i, seq[d][i]);
      end
    end
  end

  // ---------------- behavioural model ----------------
  // owner = source holding the grant (-1 while arbitrating); out_* = content
  // of the single output register.
  int            own  [2] = '{-1, -1};
  int            last [2] = '{N-1, N-1};
  int            cnt  [2] = '{0, 0};
  logic          mv   [2] = '{1'b0, 1'b0};
  logic [DW-1:0] md   [2];
  int            mid  [2] = '{0, 0};

  always @(posedge clk) begin
    logic ld;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        own[d] = -1; last[d] = N - 1; cnt[d] = 0; mv[d] = 1'b0; md[d] = '0; mid[d] = 0;
      end else begin
        ld = !mv[d] || mrdy[d];
        if (mv[d] && mrdy[d]) mv[d] = 1'b0;
        if (own[d] >= 0) begin
          if (!vld[d][own[d]]) begin
            last[d] = own[d];
            own[d]  = -1;
          end else if (ld) begin
            mv[d]  = 1'b1;
            md[d]  = dat[d][own[d]*DW +: DW];
            mid[d] = own[d];
            cnt[d]++;
            if (cnt[d] == mb(d)) begin
              last[d] = own[d];
              own[d]  = -1;
            end
          end
        end else if (vld[d] != '0) begin
          for (int k = 1; k <= N; k++) begin
            if (own[d] < 0 && vld[d][(last[d] + k) % N]) own[d] = (last[d] + k) % N;
          end
          cnt[d] = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [N-1:0] exp_r;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        exp_r = '0;
        if (own[d] >= 0 && (!mv[d] || mrdy[d])) exp_r = N'(1 << own[d]);
        check($sformatf("cyc s_ready[%0d]", d), sr[d], exp_r);
        check($sformatf("cyc busy[%0d]", d), busyo[d], own[d] >= 0);
        check($sformatf("cyc m_valid[%0d]", d), mvo[d], mv[d]);
        if (mv[d]) begin
          check($sformatf("cyc m_data[%0d]", d), mdo[d], md[d]);
          check($sformatf("cyc m_src_id[%0d]", d), mido[d], mid[d]);
        end
        check($sformatf("cyc ready_onehot[%0d]", d), $countones(sr[d]) <= 1, 1'b1);
      end
    end
  end

  // ---------------- output capture / scoreboard ----------------
  logic [IDW+DW-1:0] cap0[$];
  logic [IDW+DW-1:0] cap1[$];
  logic [IDW+DW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (mvo[0] === 1'b1 && mrdy[0]) cap0.push_back({mido[0], mdo[0]});
    if (mvo[1] === 1'b1 && mrdy[1]) cap1.push_back({mido[1], mdo[1]});
  end

  task automatic check_cap(input int d, input string name);
    logic [IDW+DW-1:0] got[$];
    if (d == 0) got = cap0;
    else got = cap1;
    check({name, " count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s beat%0d", name, i), got[i], exp_q[i]);
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld[0] = '0; vld[1] = '0;
    mrdy[0] = 1'b1; mrdy[1] = 1'b1;
    ticks(2);
    rst = 1'b0;
    cap0.delete();
    cap1.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    vld[0] = '0; vld[1] = '0; mrdy[0] = 1'b1; mrdy[1] = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) dat[d][i*DW +: DW] = data_of(i, 0);
    ticks(1);
    chk_en = 1'b1;

    // Reset values
    do_reset();
    check("rst m_valid", mvo[0], 1'b0);
    check("rst m_data", mdo[0], 32'h0);
    check("rst m_src_id", mido[0], 2'd0);
    check("rst s_ready", sr[0], 4'b0000);
    check("rst busy", busyo[0], 1'b0);

    // Single source, one full burst
    vld[0] = 4'b0001;
    tick();
    check("t1 s_ready after grant", sr[0], 4'b0001);
    check("t1 busy after grant", busyo[0], 1'b1);
    ticks(4);
    vld[0] = 4'b0000;
    check("t1 busy after 4th beat", busyo[0], 1'b0);
    check("t1 m_data 4th", mdo[0], 32'h0000_00A3);
    ticks(2);
    for (int j = 0; j < 4; j++) exp_q.push_back(ent(0, j));
    check_cap(0, "t1");

    // All sources requesting: bursts of 4 in rotation, wrap back to 0
    do_reset();
    vld[0] = 4'b1111;
    ticks(25);
    vld[0] = 4'b0000;
    ticks(3);
    for (int b = 0; b < 5; b++)
      for (int j = 0; j < 4; j++) exp_q.push_back(ent(b % 4, (b == 4 ? 4 : 0) + j));
    check_cap(0, "t2");

    // Output stalls mid-burst
    do_reset();
    vld[0] = 4'b0100;
    tick();
    mrdy[0] = 1'b1; tick();
    mrdy[0] = 1'b0; tick();
    check("t3 stall m_valid", mvo[0], 1'b1);
    check("t3 stall m_data", mdo[0], 32'h0200_00A0);
    check("t3 stall m_src_id", mido[0], 2'd2);
    check("t3 stall s_ready", sr[0], 4'b0000);
    tick();
    mrdy[0] = 1'b1;
    ticks(3);
    vld[0] = 4'b0000;
    check("t3 busy after 4 beats", busyo[0], 1'b0);
    ticks(2);
    for (int j = 0; j < 4; j++) exp_q.push_back(ent(2, j));
    check_cap(0, "t3");

    // Source 1 drops valid after 2 beats, source 3 waiting
    do_reset();
    vld[0] = 4'b1010;
    ticks(3);
    vld[0] = 4'b1000;
    tick();
    check("t4 busy after drop", busyo[0], 1'b0);
    vld[0] = 4'b1010;
    tick();
    check("t4 grant to 3", sr[0], 4'b1000);
    ticks(4);
    vld[0] = 4'b0010;
    ticks(5);
    vld[0] = 4'b0000;
    ticks(2);
    exp_q.push_back(ent(1, 0)); exp_q.push_back(ent(1, 1));
    for (int j = 0; j < 4; j++) exp_q.push_back(ent(3, j));
    for (int j = 2; j < 6; j++) exp_q.push_back(ent(1, j));
    check_cap(0, "t4");

    // Reset in the middle of a burst with the output stalled
    do_reset();
    vld[0] = 4'b0001;
    ticks(2);
    mrdy[0] = 1'b0;
    rst = 1'b1;
    tick();
    check("t5 m_valid after rst", mvo[0], 1'b0);
    check("t5 s_ready after rst", sr[0], 4'b0000);
    check("t5 busy after rst", busyo[0], 1'b0);
    rst = 1'b0;
    mrdy[0] = 1'b1;
    cap0.delete();
    tick();
    check("t5 regrant 0", sr[0], 4'b0001);
    tick();
    vld[0] = 4'b0000;
    ticks(2);
    exp_q.push_back(ent(0, 0));
    check_cap(0, "t5");

    // MAX_BURST=1: strict alternation between sources 0 and 2
    do_reset();
    vld[1] = 4'b0101;
    ticks(2);
    check("t6 idle after single beat", busyo[1], 1'b0);
    ticks(6);
    vld[1] = 4'b0000;
    ticks(2);
    exp_q.push_back(ent(0, 0)); exp_q.push_back(ent(2, 0));
    exp_q.push_back(ent(0, 1)); exp_q.push_back(ent(2, 1));
    check_cap(1, "t6");

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
